// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the ST7789 panel initialiser:
//   - lcd_state_t      : init sequencer state encoding
//   - DC_BIT           : position of the command/data flag in a 9-bit write
//   - MADCTL_*         : memory-access-control bytes per panel orientation
//   - RGB565_*         : handy colour constants for the clear-screen fill
//   - CMD_*            : opcodes the window/fill logic emits itself
//   - lcdCmd/lcdData   : build a 9-bit write word from a payload byte
//   - madctlFor        : orientation code to MADCTL byte
// ---------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_RST_LOW  = 3'd0,
        ST_RST_WAIT = 3'd1,
        ST_CMD_SEQ  = 3'd2,
        ST_SLP_WAIT = 3'd3,
        ST_WIN_SET  = 3'd4,
        ST_FILL     = 3'd5,
        ST_DONE     = 3'd6
    } lcd_state_t;

    localparam int DC_BIT = 8;

    localparam logic [7:0] MADCTL_PORTRAIT       = 8'h00;
    localparam logic [7:0] MADCTL_LANDSCAPE      = 8'h70;
    localparam logic [7:0] MADCTL_PORTRAIT_FLIP  = 8'hC0;
    localparam logic [7:0] MADCTL_LANDSCAPE_FLIP = 8'hA0;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;

    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_RASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;
    localparam logic [7:0] CMD_MADCTL = 8'h36;

    // Lengths of the two indexed write lists and where MADCTL sits in the ROM
    localparam int INIT_LEN        = 58;
    localparam int INIT_MADCTL_IDX = 2;
    localparam int WIN_LEN         = 13;

    // A command word carries the flag low, a data word carries it high
    function automatic logic [8:0] lcdCmd(input logic [7:0] b);
        logic [8:0] w;
        w         = {1'b0, b};
        w[DC_BIT] = 1'b0;
        return w;
    endfunction

    function automatic logic [8:0] lcdData(input logic [7:0] b);
        logic [8:0] w;
        w         = {1'b0, b};
        w[DC_BIT] = 1'b1;
        return w;
    endfunction

    // Orientation code: 0 portrait, 1 landscape, 2 portrait-flipped, 3 landscape-flipped
    function automatic logic [7:0] madctlFor(input logic [1:0] o);
        logic [7:0] m;
        case (o)
            2'd0:    m = MADCTL_PORTRAIT;
            2'd1:    m = MADCTL_LANDSCAPE;
            2'd2:    m = MADCTL_PORTRAIT_FLIP;
            default: m = MADCTL_LANDSCAPE_FLIP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// ---------------------------------------------------------------------------
// lcd_init_rom
// Fixed 58-entry ST7789 power-up command list, purely combinational.
//   i_idx   : entry index (0..57; anything higher reads as 9'h000)
//   o_entry : 9-bit write word, bit 8 = data flag, bits 7:0 = payload
// Entry 2 holds the portrait MADCTL byte; the parent substitutes the
// MADCTL byte for the latched orientation.
// ---------------------------------------------------------------------------
module lcd_init_rom
    import lcd_pkg::*;
(
    input  logic [5:0] i_idx,
    output logic [8:0] o_entry
);

    // Sleep-out, pixel format, porch/gate/power settings, both gamma tables,
    // then inversion on and display on.
    always_comb begin
        o_entry = 9'h000;
        case (i_idx)
            6'd0:  o_entry = lcdCmd(8'h11);
            6'd1:  o_entry = lcdCmd(CMD_MADCTL);
            6'd2:  o_entry = lcdData(MADCTL_PORTRAIT);
            6'd3:  o_entry = lcdCmd(8'h3A);
            6'd4:  o_entry = lcdData(8'h05);
            6'd5:  o_entry = lcdCmd(8'hB2);
            6'd6:  o_entry = lcdData(8'h0C);
            6'd7:  o_entry = lcdData(8'h0C);
            6'd8:  o_entry = lcdData(8'h00);
            6'd9:  o_entry = lcdData(8'h33);
            6'd10: o_entry = lcdData(8'h33);
            6'd11: o_entry = lcdCmd(8'hB7);
            6'd12: o_entry = lcdData(8'h35);
            6'd13: o_entry = lcdCmd(8'hBB);
            6'd14: o_entry = lcdData(8'h19);
            6'd15: o_entry = lcdCmd(8'hC0);
            6'd16: o_entry = lcdData(8'h2C);
            6'd17: o_entry = lcdCmd(8'hC2);
            6'd18: o_entry = lcdData(8'h01);
            6'd19: o_entry = lcdCmd(8'hC3);
            6'd20: o_entry = lcdData(8'h12);
            6'd21: o_entry = lcdCmd(8'hC4);
            6'd22: o_entry = lcdData(8'h20);
            6'd23: o_entry = lcdCmd(8'hD0);
            6'd24: o_entry = lcdData(8'hA4);
            6'd25: o_entry = lcdData(8'hA1);
            6'd26: o_entry = lcdCmd(8'hE0);
            6'd27: o_entry = lcdData(8'hD0);
            6'd28: o_entry = lcdData(8'h04);
            6'd29: o_entry = lcdData(8'h0D);
            6'd30: o_entry = lcdData(8'h11);
            6'd31: o_entry = lcdData(8'h13);
            6'd32: o_entry = lcdData(8'h2B);
            6'd33: o_entry = lcdData(8'h3F);
            6'd34: o_entry = lcdData(8'h54);
            6'd35: o_entry = lcdData(8'h4C);
            6'd36: o_entry = lcdData(8'h18);
            6'd37: o_entry = lcdData(8'h0D);
            6'd38: o_entry = lcdData(8'h0B);
            6'd39: o_entry = lcdData(8'h1F);
            6'd40: o_entry = lcdData(8'h23);
            6'd41: o_entry = lcdCmd(8'hE1);
            6'd42: o_entry = lcdData(8'hD0);
            6'd43: o_entry = lcdData(8'h04);
            6'd44: o_entry = lcdData(8'h0C);
            6'd45: o_entry = lcdData(8'h11);
            6'd46: o_entry = lcdData(8'h13);
            6'd47: o_entry = lcdData(8'h2C);
            6'd48: o_entry = lcdData(8'h3F);
            6'd49: o_entry = lcdData(8'h44);
            6'd50: o_entry = lcdData(8'h51);
            6'd51: o_entry = lcdData(8'h2F);
            6'd52: o_entry = lcdData(8'h1F);
            6'd53: o_entry = lcdData(8'h1F);
            6'd54: o_entry = lcdData(8'h20);
            6'd55: o_entry = lcdData(8'h23);
            6'd56: o_entry = lcdCmd(8'h21);
            6'd57: o_entry = lcdCmd(8'h29);
            default: o_entry = 9'h000;
        endcase
    end

endmodule

// File: rtl/lcd_init_cfg.sv
// ---------------------------------------------------------------------------
// lcd_init_cfg
// Brings an ST7789 panel out of reset: hardware reset pulse, init command
// list, sleep-out wait, full-screen address window, then a solid colour fill.
// Ports:
//   sys_clk_50MHz : sole clock, rising edge
//   sys_rst_n     : asynchronous active-low reset
//   wr_done       : one-cycle pulse from the SPI writer, init_data was sent
//   orient        : panel orientation, sampled on entry to the reset phase
//   fill_color    : RGB565 clear colour, sampled with orient
//   reinit        : one-cycle request to restart the whole sequence
//   lcd_rst       : panel reset, active low
//   init_data     : 9-bit write word (bit 8 = data flag)
//   en_write      : a write is being offered to the SPI writer
//   init_done     : sequence complete
// ---------------------------------------------------------------------------
module lcd_init_cfg
    import lcd_pkg::*;
#(
    parameter int unsigned H_RES      = 160,
    parameter int unsigned V_RES      = 240,
    parameter int unsigned T_RST_LOW  = 5_000_000,
    parameter int unsigned T_RST_WAIT = 2_500_000,
    parameter int unsigned T_SLP_WAIT = 6_000_000,
    parameter logic [8:0]  DATA_IDLE  = 9'h000
) (
    input  logic        sys_clk_50MHz,
    input  logic        sys_rst_n,
    input  logic        wr_done,
    input  logic [1:0]  orient,
    input  logic [15:0] fill_color,
    input  logic        reinit,
    output logic        lcd_rst,
    output logic [8:0]  init_data,
    output logic        en_write,
    output logic        init_done
);

    localparam int unsigned T_MAX_A = (T_RST_LOW > T_RST_WAIT) ? T_RST_LOW : T_RST_WAIT;
    localparam int unsigned T_MAX   = (T_MAX_A > T_SLP_WAIT) ? T_MAX_A : T_SLP_WAIT;
    localparam int          CNT_W   = $clog2(T_MAX + 1);
    localparam int unsigned PIX_N   = H_RES * V_RES;
    localparam int          PIX_W   = $clog2(PIX_N + 1);
    localparam logic [15:0] H_END   = 16'(H_RES - 1);
    localparam logic [15:0] V_END   = 16'(V_RES - 1);

    lcd_state_t       r_state;
    lcd_state_t       w_nextState;
    logic             w_entry;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_idx;
    logic [PIX_W-1:0] r_pix;
    logic             r_phase;
    logic [1:0]       r_orient;
    logic [15:0]      r_fill;
    logic             r_lcdRst;
    logic [8:0]       w_romEntry;
    logic [8:0]       w_winEntry;
    logic [7:0]       w_madctl;
    logic [15:0]      w_colEnd;
    logic [15:0]      w_rowEnd;

    lcd_init_rom u_rom (
        .i_idx   (r_idx),
        .o_entry (w_romEntry)
    );

    assign w_madctl = madctlFor(r_orient);
    assign lcd_rst  = r_lcdRst;

    // Landscape orientations swap the column and row extents of the window
    assign w_colEnd = r_orient[0] ? V_END : H_END;
    assign w_rowEnd = r_orient[0] ? H_END : V_END;

    // State register; everything else keys off the state it holds
    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_RST_LOW;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Delay states leave one cycle before the counter
    // would reach its limit, so each lasts exactly T cycles. Write states
    // leave on the acknowledge of their last word. reinit overrides all,
    // including a coincident wr_done.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_RST_LOW:  if (r_cnt == CNT_W'(T_RST_LOW - 1))  w_nextState = ST_RST_WAIT;
            ST_RST_WAIT: if (r_cnt == CNT_W'(T_RST_WAIT - 1)) w_nextState = ST_CMD_SEQ;
            ST_CMD_SEQ:  if (wr_done && r_idx == 6'(INIT_LEN - 1)) w_nextState = ST_SLP_WAIT;
            ST_SLP_WAIT: if (r_cnt == CNT_W'(T_SLP_WAIT - 1)) w_nextState = ST_WIN_SET;
            ST_WIN_SET:  if (wr_done && r_idx == 6'(WIN_LEN - 1)) w_nextState = ST_FILL;
            ST_FILL:     if (wr_done && r_phase && r_pix == PIX_W'(PIX_N - 1)) w_nextState = ST_DONE;
            ST_DONE:     w_nextState = ST_DONE;
            default:     w_nextState = ST_RST_LOW;
        endcase
        if (reinit) begin
            w_nextState = ST_RST_LOW;
        end
    end

    // Every state entry (including a reinit while already in RST_LOW)
    assign w_entry = reinit || (w_nextState != r_state);

    // Delay, list index and pixel counters. All clear on state entry; only
    // the counter that belongs to the current state moves, so wr_done in a
    // delay state or in DONE has nowhere to go.
    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_pix   <= '0;
            r_phase <= 1'b0;
        end else if (w_entry) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_pix   <= '0;
            r_phase <= 1'b0;
        end else begin
            case (r_state)
                ST_RST_LOW, ST_RST_WAIT, ST_SLP_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                ST_CMD_SEQ, ST_WIN_SET: begin
                    if (wr_done) begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                ST_FILL: begin
                    if (wr_done) begin
                        r_phase <= ~r_phase;
                        if (r_phase) begin
                            r_pix <= r_pix + PIX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Panel reset line: released when the reset-low phase completes, pulled
    // low again only by reinit or system reset
    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_lcdRst <= 1'b0;
        end else if (reinit) begin
            r_lcdRst <= 1'b0;
        end else if (r_state == ST_RST_LOW && w_nextState == ST_RST_WAIT) begin
            r_lcdRst <= 1'b1;
        end
    end

    // Orientation and fill colour are captured during the first cycle of
    // RST_LOW, so they stay fixed for the whole sequence that follows
    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_orient <= 2'd0;
            r_fill   <= 16'h0000;
        end else if (r_state == ST_RST_LOW && r_cnt == '0) begin
            r_orient <= orient;
            r_fill   <= fill_color;
        end
    end

    // Address-window list: MADCTL again, full-panel CASET/RASET, then RAMWR
    always_comb begin
        w_winEntry = DATA_IDLE;
        case (r_idx)
            6'd0:  w_winEntry = lcdCmd(CMD_MADCTL);
            6'd1:  w_winEntry = lcdData(w_madctl);
            6'd2:  w_winEntry = lcdCmd(CMD_CASET);
            6'd3:  w_winEntry = lcdData(8'h00);
            6'd4:  w_winEntry = lcdData(8'h00);
            6'd5:  w_winEntry = lcdData(w_colEnd[15:8]);
            6'd6:  w_winEntry = lcdData(w_colEnd[7:0]);
            6'd7:  w_winEntry = lcdCmd(CMD_RASET);
            6'd8:  w_winEntry = lcdData(8'h00);
            6'd9:  w_winEntry = lcdData(8'h00);
            6'd10: w_winEntry = lcdData(w_rowEnd[15:8]);
            6'd11: w_winEntry = lcdData(w_rowEnd[7:0]);
            6'd12: w_winEntry = lcdCmd(CMD_RAMWR);
            default: w_winEntry = DATA_IDLE;
        endcase
    end

    // Outputs are decoded from registered state only, so a new word appears
    // the cycle after the wr_done that advanced the index and stays put
    // until the next wr_done
    always_comb begin
        init_data = DATA_IDLE;
        en_write  = 1'b0;
        init_done = 1'b0;
        case (r_state)
            ST_CMD_SEQ: begin
                en_write  = 1'b1;
                init_data = (r_idx == 6'(INIT_MADCTL_IDX)) ? lcdData(w_madctl) : w_romEntry;
            end
            ST_WIN_SET: begin
                en_write  = 1'b1;
                init_data = w_winEntry;
            end
            ST_FILL: begin
                en_write  = 1'b1;
                init_data = lcdData(r_phase ? r_fill[7:0] : r_fill[15:8]);
            end
            ST_DONE: begin
                init_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lcd_init_cfg.sv
// ---------------------------------------------------------------------------
// tb_lcd_init_cfg
// Drives lcd_init_cfg with a small panel and short delays, acknowledges each
// offered write three cycles later, records every acknowledged word and
// compares the recorded stream with one built from the panel rules.
// ---------------------------------------------------------------------------
module tb_lcd_init_cfg;
    import lcd_pkg::*;

    localparam int H = 4;
    localparam int V = 2;
    localparam int T = 10;
    localparam int STREAM_LEN = 58 + 13 + 2 * H * V;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        wrDoneModel = 1'b0;
    logic        wrDoneForce = 1'b0;
    logic        wrDone;
    logic        reinit = 1'b0;
    logic [1:0]  orient = 2'd0;
    logic [15:0] fillColor = 16'h0000;
    logic        lcdRst;
    logic [8:0]  initData;
    logic        enWrite;
    logic        initDone;

    int total = 0;
    int bad = 0;

    logic [8:0] sent[$];
    logic [8:0] expQ[$];

    // Init list as documented for the panel; entry 2 is replaced by MADCTL
    logic [8:0] initTbl [58] = '{
        9'h011, 9'h036, 9'h100, 9'h03A, 9'h105,
        9'h0B2, 9'h10C, 9'h10C, 9'h100, 9'h133, 9'h133,
        9'h0B7, 9'h135, 9'h0BB, 9'h119, 9'h0C0, 9'h12C,
        9'h0C2, 9'h101, 9'h0C3, 9'h112, 9'h0C4, 9'h120,
        9'h0D0, 9'h1A4, 9'h1A1,
        9'h0E0, 9'h1D0, 9'h104, 9'h10D, 9'h111, 9'h113, 9'h12B, 9'h13F,
        9'h154, 9'h14C, 9'h118, 9'h10D, 9'h10B, 9'h11F, 9'h123,
        9'h0E1, 9'h1D0, 9'h104, 9'h10C, 9'h111, 9'h113, 9'h12C, 9'h13F,
        9'h144, 9'h151, 9'h12F, 9'h11F, 9'h11F, 9'h120, 9'h123,
        9'h021, 9'h029
    };

    assign wrDone = wrDoneModel | wrDoneForce;

    lcd_init_cfg #(
        .H_RES      (H),
        .V_RES      (V),
        .T_RST_LOW  (T),
        .T_RST_WAIT (T),
        .T_SLP_WAIT (T),
        .DATA_IDLE  (9'h000)
    ) dut (
        .sys_clk_50MHz (clk),
        .sys_rst_n     (rstN),
        .wr_done       (wrDone),
        .orient        (orient),
        .fill_color    (fillColor),
        .reinit        (reinit),
        .lcd_rst       (lcdRst),
        .init_data     (initData),
        .en_write      (enWrite),
        .init_done     (initDone)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected acknowledged-word stream for one complete init sequence
    function automatic void buildExpected(input logic [1:0] o, input logic [15:0] fc);
        logic [7:0] mad;
        int w;
        int h;
        expQ.delete();
        case (o)
            2'd0:    mad = 8'h00;
            2'd1:    mad = 8'h70;
            2'd2:    mad = 8'hC0;
            default: mad = 8'hA0;
        endcase
        for (int i = 0; i < 58; i++) begin
            expQ.push_back((i == 2) ? {1'b1, mad} : initTbl[i]);
        end
        w = (o == 2'd1 || o == 2'd3) ? V : H;
        h = (o == 2'd1 || o == 2'd3) ? H : V;
        expQ.push_back(9'h036);
        expQ.push_back({1'b1, mad});
        expQ.push_back(9'h02A);
        expQ.push_back(9'h100);
        expQ.push_back(9'h100);
        expQ.push_back({1'b1, 8'((w - 1) / 256)});
        expQ.push_back({1'b1, 8'((w - 1) % 256)});
        expQ.push_back(9'h02B);
        expQ.push_back(9'h100);
        expQ.push_back(9'h100);
        expQ.push_back({1'b1, 8'((h - 1) / 256)});
        expQ.push_back({1'b1, 8'((h - 1) % 256)});
        expQ.push_back(9'h02C);
        for (int p = 0; p < H * V; p++) begin
            expQ.push_back({1'b1, fc[15:8]});
            expQ.push_back({1'b1, fc[7:0]});
        end
    endfunction

    task automatic compareStream(input string tag, input logic [1:0] o, input logic [15:0] fc);
        buildExpected(o, fc);
        checkOutput({tag, "_len"}, 32'(sent.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("%s_w%0d", tag, i),
                        32'((i < sent.size()) ? sent[i] : 9'h1FF), 32'(expQ[i]));
        end
    endtask

    task automatic waitSent(input int n, input string tag);
        int c = 0;
        while (sent.size() < n && c < 5000) begin
            @(negedge clk);
            c++;
        end
        checkOutput(tag, 32'(sent.size() >= n), 32'd1);
    endtask

    task automatic waitDone(input string tag);
        int c = 0;
        while (initDone !== 1'b1 && c < 5000) begin
            @(negedge clk);
            c++;
        end
        checkOutput(tag, 32'(initDone), 32'd1);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_lcdRst"}, 32'(lcdRst), 32'd0);
        checkOutput({tag, "_enWrite"}, 32'(enWrite), 32'd0);
        checkOutput({tag, "_initData"}, 32'(initData), 32'd0);
        checkOutput({tag, "_initDone"}, 32'(initDone), 32'd0);
    endtask

    // Set the panel inputs and pulse reinit; the sequencer must be back in
    // its reset phase one cycle later
    task automatic applyStimulus(input logic [1:0] o, input logic [15:0] fc, input string tag);
        orient    = o;
        fillColor = fc;
        reinit    = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        checkIdle(tag);
        sent.delete();
    endtask

    // SPI writer stand-in: acknowledges each offered word three cycles after
    // it appears, checking the word did not change while waiting
    initial begin
        logic [8:0] held;
        forever begin
            @(negedge clk);
            if (rstN && enWrite) begin
                held = initData;
                repeat (2) @(negedge clk);
                if (rstN && enWrite) begin
                    checkOutput("holdStable", 32'(initData), 32'(held));
                    sent.push_back(initData);
                    wrDoneModel = 1'b1;
                    @(negedge clk);
                    wrDoneModel = 1'b0;
                end
            end
        end
    end

    initial begin
        int lowCycles;
        logic [1:0]  o;
        logic [15:0] fc;

        // Reset state
        orient    = 2'd0;
        fillColor = RGB565_RED;
        repeat (3) @(negedge clk);
        checkIdle("reset");

        // Run 1: portrait, red; colour changed mid-fill must not show up
        rstN = 1'b1;
        lowCycles = 0;
        while (lcdRst === 1'b0 && lowCycles < 100) begin
            lowCycles++;
            @(negedge clk);
        end
        checkOutput("rstLowCycles", 32'(lowCycles), 32'd10);
        waitSent(58, "run1_cmdSeq");
        repeat (2) @(negedge clk);
        checkOutput("slp_enWrite", 32'(enWrite), 32'd0);
        wrDoneForce = 1'b1;
        @(negedge clk);
        wrDoneForce = 1'b0;
        checkOutput("slpSpur_enWrite", 32'(enWrite), 32'd0);
        checkOutput("slpSpur_initData", 32'(initData), 32'd0);
        checkOutput("slpSpur_lcdRst", 32'(lcdRst), 32'd1);
        waitSent(71, "run1_win");
        fillColor = RGB565_BLUE;
        waitDone("run1_done");
        compareStream("run1", 2'd0, RGB565_RED);
        checkOutput("run1_madctl", 32'(sent[2]), 32'h100);
        checkOutput("run1_colEnd", 32'(sent[64]), 32'h103);
        checkOutput("run1_rowEnd", 32'(sent[69]), 32'h101);
        checkOutput("run1_fillHi", 32'(sent[71]), 32'h1F8);
        checkOutput("run1_fillLo", 32'(sent[86]), 32'h100);

        // Spurious acknowledge in DONE changes nothing
        wrDoneForce = 1'b1;
        @(negedge clk);
        wrDoneForce = 1'b0;
        @(negedge clk);
        checkOutput("doneSpur_initDone", 32'(initDone), 32'd1);
        checkOutput("doneSpur_enWrite", 32'(enWrite), 32'd0);
        checkOutput("doneSpur_initData", 32'(initData), 32'd0);
        checkOutput("doneSpur_count", 32'(sent.size()), 32'(STREAM_LEN));

        // Run 2: landscape, random colour
        fc = 16'($urandom);
        applyStimulus(2'd1, fc, "reinit2");
        waitDone("run2_done");
        compareStream("run2", 2'd1, fc);
        checkOutput("run2_madctl", 32'(sent[59]), 32'h170);
        checkOutput("run2_colEnd", 32'(sent[64]), 32'h101);
        checkOutput("run2_rowEnd", 32'(sent[69]), 32'h103);

        // Run 3: random orientation; reinit together with wr_done at fill byte 5
        o  = 2'($urandom_range(0, 3));
        fc = 16'($urandom);
        applyStimulus(o, fc, "reinit3");
        waitSent(76, "run3_fill5");
        @(negedge clk);
        reinit      = 1'b1;
        wrDoneForce = 1'b1;
        @(negedge clk);
        reinit      = 1'b0;
        wrDoneForce = 1'b0;
        checkIdle("abort3");
        sent.delete();
        waitDone("run3_done");
        compareStream("run3", o, fc);

        // Run 4: system reset mid-fill, then a clean sequence
        o  = 2'($urandom_range(0, 3));
        fc = 16'($urandom);
        applyStimulus(o, fc, "reinit4");
        waitSent(74, "run4_fill");
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkIdle("midFillReset");
        @(negedge clk);
        sent.delete();
        rstN = 1'b1;
        waitDone("run4_done");
        compareStream("run4", o, fc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_init_cfg.md
LCD_INIT_CFG -- requirements
Module: lcd_init_cfg

Interface
REQ-001 H_RES, default 160, panel native width in pixels (column count in portrait).
REQ-002 V_RES, default 240, panel native height in pixels (row count in portrait).
REQ-003 T_RST_LOW, default 5_000_000, cycles lcd_rst is held low (100 ms at 50 MHz).
REQ-004 T_RST_WAIT, default 2_500_000, cycles of wait after lcd_rst rises (50 ms).
REQ-005 T_SLP_WAIT, default 6_000_000, cycles of wait after the init command list (120 ms).
REQ-006 DATA_IDLE, default 9'h000, value of init_data whenever no write is pending.
REQ-007 sys_clk_50MHz  in  1  sole clock; all logic is on the rising edge.
REQ-008 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-009 wr_done  in  1  one-cycle pulse from the SPI writer: current init_data has been sent.
REQ-010 orient  in  2  0 portrait, 1 landscape, 2 portrait-flipped, 3 landscape-flipped.
REQ-011 fill_color  in  16  RGB565 colour used for the clear-screen fill.
REQ-012 reinit  in  1  one-cycle request to restart the full init sequence.
REQ-013 lcd_rst  out  1  panel hardware reset, active low.
REQ-014 init_data  out  9  bit 8 = 1 for data, 0 for command; bits 7:0 are the payload byte.
REQ-015 en_write  out  1  high while a command, window or fill write is active.
REQ-016 init_done  out  1  high only in the DONE state.

Function
REQ-017 The block SHALL be a state machine with states RST_LOW, RST_WAIT, CMD_SEQ, SLP_WAIT, WIN_SET, FILL and DONE, in that order; after reset it enters RST_LOW.
REQ-018 The delay counter SHALL clear on every state entry; RST_LOW, RST_WAIT and SLP_WAIT each exit when the counter reaches T_RST_LOW, T_RST_WAIT and T_SLP_WAIT respectively.
REQ-019 lcd_rst SHALL rise on the RST_LOW-to-RST_WAIT transition and then hold high until reset or reinit.
REQ-020 On entry to RST_LOW, orient and fill_color SHALL be latched; later changes on these inputs have no effect until the next entry.
REQ-021 CMD_SEQ SHALL emit the 58-entry ST7789 list (0x11, 0x36, MADCTL, 0x3A, 0x05 … 0x21, 0x29), one entry per wr_done.
- Entry 2 (MADCTL) is substituted from the latched orient: 0 → 0x00, 1 → 0x70, 2 → 0xC0, 3 → 0xA0.
REQ-022 Handshake: the index SHALL advance on wr_done, and init_data SHALL present the new entry on the following cycle; init_data SHALL hold stable between wr_done pulses.
REQ-023 CMD_SEQ SHALL exit on the wr_done of the last entry.
REQ-024 WIN_SET SHALL emit, in order:
- 0x36, MADCTL;
- 0x2A, 0x00, 0x00, (W-1)[15:8], (W-1)[7:0];
- 0x2B, 0x00, 0x00, (H-1)[15:8], (H-1)[7:0];
- 0x2C.
- W = H_RES and H = V_RES for orient 0/2; the two are swapped for orient 1/3.
REQ-025 FILL SHALL emit H_RES*V_RES pixels, each as the high byte then the low byte of the latched fill_color with bit 8 = 1.
- Pixel count is tracked in a counter of width clog2(H_RES*V_RES+1) plus a byte-phase bit.
REQ-026 FILL SHALL exit to DONE on the wr_done of the final low byte, with no extra or missing byte.
REQ-027 en_write SHALL be high exactly in CMD_SEQ, WIN_SET and FILL; init_data SHALL be DATA_IDLE in all other states.
REQ-028 wr_done received in RST_LOW, RST_WAIT, SLP_WAIT or DONE SHALL be ignored.
REQ-029 reinit in any state SHALL, on the next cycle, abort the current operation and enter RST_LOW with lcd_rst low and all counters cleared.
REQ-030 reinit and wr_done in the same cycle: reinit wins.
REQ-031 In DONE, the block SHALL hold init_done = 1 until reinit or reset.

Reset
REQ-032 While sys_rst_n is low, all outputs SHALL be as follows: state = RST_LOW, lcd_rst = 0, init_data = DATA_IDLE, en_write = 0, init_done = 0, all counters = 0.
REQ-033 Reset assertion mid-fill SHALL abort immediately, with no partial-state retention.

Structure
REQ-034 A shared package lcd_pkg SHALL hold:
- the state encoding;
- the command/data bit position;
- the MADCTL orientation constants;
- the RGB565 colour constants;
- the command opcodes 0x2A, 0x2B, 0x2C, 0x36.
REQ-035 The 58-entry command list SHALL live in a sub-module lcd_init_rom (6-bit index in, 9-bit entry out, purely combinational); lcd_init_cfg performs the MADCTL substitution.

Verification
REQ-036 Bench parameters: H_RES=4, V_RES=2, all T_* = 10, with a wr_done model that pulses 3 cycles after each write.
REQ-037 Reset release, orient=0, fill_color=16'hF800 → lcd_rst low for 10 cycles then high; 58 CMD_SEQ writes with entry 2 = 9'h100; window ends 0x103/0x101; exactly 16 fill bytes alternating 9'h1F8/9'h100; then init_done = 1.
REQ-038 orient=1 → MADCTL 9'h170; column end low byte 9'h101; row end low byte 9'h103; 8 pixels filled.
REQ-039 Change fill_color to 16'h001F during the FILL state → fill bytes remain 9'h1F8/9'h100 (latched value used).
REQ-040 reinit pulsed at fill byte 5 → next cycle: lcd_rst = 0, en_write = 0, init_data = DATA_IDLE; the full sequence then replays.
REQ-041 Spurious wr_done pulses during SLP_WAIT and DONE → no index advance and no output change; reinit coincident with wr_done → restart occurs.
